// File: rtl/alu_pkg.sv
// ============================================================================
// alu_pkg : op codes and handshake FSM states shared by the alu_seq slice
// Rev 1.0 : initial release
// ============================================================================
`default_nettype none

package alu_pkg;

  localparam logic [2:0] ALUOP_AND  = 3'b000;
  localparam logic [2:0] ALUOP_OR   = 3'b001;
  localparam logic [2:0] ALUOP_ADD  = 3'b010;
  localparam logic [2:0] ALUOP_MULU = 3'b011;
  localparam logic [2:0] ALUOP_NOR  = 3'b100;
  localparam logic [2:0] ALUOP_DIVU = 3'b101;
  localparam logic [2:0] ALUOP_SUB  = 3'b110;
  localparam logic [2:0] ALUOP_SLTU = 3'b111;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    DIV  = 2'd2,
    DONE = 2'd3
  } alu_state_t;

endpackage

`default_nettype wire

// File: rtl/alu_iter_unit.sv
// ============================================================================
// alu_iter_unit : shift-add multiplier / restoring divider, one bit per cycle
// Divider datapath present only when ALU_SEQ_DIV_EN is defined.
// Rev 1.0 : initial release
// ============================================================================
`default_nettype none

module alu_iter_unit
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             is_div,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             done,
  output logic [WIDTH-1:0] res_lo,
  output logic [WIDTH-1:0] res_hi
);

  logic             r_busy;
  logic [WIDTH-1:0] r_cnt;
  logic [WIDTH-1:0] r_hi;
  logic [WIDTH-1:0] r_lo;
  logic [WIDTH-1:0] r_opb;
  logic [WIDTH-1:0] w_hi_nxt;
  logic [WIDTH-1:0] w_lo_nxt;
  logic [WIDTH:0]   w_mul_sum;

  // {carry, hi, lo} shifts right once per step; lo starts as the multiplier
  assign w_mul_sum = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_opb} : '0);

`ifdef ALU_SEQ_DIV_EN
  logic             r_is_div;
  logic [WIDTH:0]   w_trial;
  logic             w_ge;
  logic [WIDTH-1:0] w_diff;

  // Remainder is always below the divisor, so the difference fits in WIDTH bits
  assign w_trial = {r_hi, r_lo[WIDTH-1]};
  assign w_ge    = (w_trial >= {1'b0, r_opb});
  assign w_diff  = w_trial[WIDTH-1:0] - r_opb;

  always_comb begin
    if (r_is_div) begin
      w_hi_nxt = w_ge ? w_diff : w_trial[WIDTH-1:0];
      w_lo_nxt = {r_lo[WIDTH-2:0], w_ge};
    end else begin
      w_hi_nxt = w_mul_sum[WIDTH:1];
      w_lo_nxt = {w_mul_sum[0], r_lo[WIDTH-1:1]};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_is_div <= 1'b0;
    end else if (start) begin
      r_is_div <= is_div;
    end
  end
`else
  logic w_unused_is_div;

  assign w_unused_is_div = is_div;
  assign w_hi_nxt        = w_mul_sum[WIDTH:1];
  assign w_lo_nxt        = {w_mul_sum[0], r_lo[WIDTH-1:1]};
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_busy <= 1'b0;
      r_cnt  <= '0;
      r_hi   <= '0;
      r_lo   <= '0;
      r_opb  <= '0;
    end else if (start) begin
      r_busy <= 1'b1;
      r_cnt  <= WIDTH'(WIDTH - 1);
      r_hi   <= '0;
      r_lo   <= a;
      r_opb  <= b;
    end else if (r_busy) begin
      r_hi  <= w_hi_nxt;
      r_lo  <= w_lo_nxt;
      r_cnt <= r_cnt - 1'b1;
      if (r_cnt == '0) begin
        r_busy <= 1'b0;
      end
    end
  end

  // The final step's value is handed over directly, so no extra cycle is spent
  assign done   = r_busy && (r_cnt == '0);
  assign res_lo = w_lo_nxt;
  assign res_hi = w_hi_nxt;

endmodule

`default_nettype wire

// File: rtl/alu_seq.sv
// ============================================================================
// alu_seq : handshaked ALU with single-cycle logic/arith and iterative MULU/DIVU
// DIVU datapath compiled in only when ALU_SEQ_DIV_EN is defined.
// Rev 1.0 : initial release
// ============================================================================
`default_nettype none

module alu_seq
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [2:0]       aluop,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result_lo,
  output logic [WIDTH-1:0] result_hi,
  output logic             zero,
  output logic             overflow,
  output logic             div_by_zero,
  output logic             illegal
);

  alu_state_t       r_state;
  alu_state_t       w_state_nxt;
  logic             w_accept;
  logic             w_start;
  logic             w_start_div;
  logic             w_load;
  logic [WIDTH-1:0] w_lo_nxt;
  logic [WIDTH-1:0] w_hi_nxt;
  logic             w_ovf_nxt;
  logic             w_dbz_nxt;
  logic             w_ill_nxt;
  logic [WIDTH-1:0] w_sum;
  logic [WIDTH-1:0] w_diff;
  logic             w_iter_done;
  logic [WIDTH-1:0] w_iter_lo;
  logic [WIDTH-1:0] w_iter_hi;

  assign in_ready  = !rst && ((r_state == IDLE) || ((r_state == DONE) && out_ready));
  assign w_accept  = in_valid && in_ready;
  assign out_valid = (r_state == DONE);
  assign w_sum     = a + b;
  assign w_diff    = a - b;

  alu_iter_unit #(
    .WIDTH (WIDTH)
  ) u_iter (
    .clk    (clk),
    .rst    (rst),
    .start  (w_start),
    .is_div (w_start_div),
    .a      (a),
    .b      (b),
    .done   (w_iter_done),
    .res_lo (w_iter_lo),
    .res_hi (w_iter_hi)
  );

  always_comb begin
    w_state_nxt = r_state;
    w_start     = 1'b0;
    w_start_div = 1'b0;
    w_load      = 1'b0;
    w_lo_nxt    = '0;
    w_hi_nxt    = '0;
    w_ovf_nxt   = 1'b0;
    w_dbz_nxt   = 1'b0;
    w_ill_nxt   = 1'b0;
    case (r_state)
      MUL, DIV: begin
        if (w_iter_done) begin
          w_state_nxt = DONE;
          w_load      = 1'b1;
          w_lo_nxt    = w_iter_lo;
          w_hi_nxt    = w_iter_hi;
        end
      end
      default: begin
        if ((r_state == DONE) && out_ready) begin
          w_state_nxt = IDLE;
        end
        if (w_accept) begin
          w_state_nxt = DONE;
          w_load      = 1'b1;
          case (aluop)
            ALUOP_AND:  w_lo_nxt = a & b;
            ALUOP_OR:   w_lo_nxt = a | b;
            ALUOP_NOR:  w_lo_nxt = ~(a | b);
            ALUOP_SLTU: w_lo_nxt = {{(WIDTH-1){1'b0}}, (a < b)};
            ALUOP_ADD: begin
              w_lo_nxt  = w_sum;
              w_ovf_nxt = (a[WIDTH-1] == b[WIDTH-1]) && (w_sum[WIDTH-1] != a[WIDTH-1]);
            end
            ALUOP_SUB: begin
              w_lo_nxt  = w_diff;
              w_ovf_nxt = (a[WIDTH-1] != b[WIDTH-1]) && (w_diff[WIDTH-1] != a[WIDTH-1]);
            end
            ALUOP_MULU: begin
              w_state_nxt = MUL;
              w_load      = 1'b0;
              w_start     = 1'b1;
            end
            ALUOP_DIVU: begin
`ifdef ALU_SEQ_DIV_EN
              if (b == '0) begin
                w_lo_nxt  = '1;
                w_hi_nxt  = a;
                w_dbz_nxt = 1'b1;
              end else begin
                w_state_nxt = DIV;
                w_load      = 1'b0;
                w_start     = 1'b1;
                w_start_div = 1'b1;
              end
`else
              w_ill_nxt = 1'b1;
`endif
            end
            default: w_ill_nxt = 1'b1;
          endcase
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= IDLE;
      result_lo   <= '0;
      result_hi   <= '0;
      zero        <= 1'b0;
      overflow    <= 1'b0;
      div_by_zero <= 1'b0;
      illegal     <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      // Results only move on a completion, so they hold under backpressure
      if (w_load) begin
        result_lo   <= w_lo_nxt;
        result_hi   <= w_hi_nxt;
        zero        <= (w_lo_nxt == '0);
        overflow    <= w_ovf_nxt;
        div_by_zero <= w_dbz_nxt;
        illegal     <= w_ill_nxt;
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_alu_seq.sv
// ============================================================================
// tb_alu_seq : randomized self-checking bench for alu_seq against an
// arithmetic reference model (honours ALU_SEQ_DIV_EN like the design).
// Rev 1.0 : initial release
// ============================================================================
`default_nettype none

module tb_alu_seq;
  import alu_pkg::*;

  localparam int W = 32;
  localparam longint MAXS = (longint'(1) << (W - 1)) - 1;
  localparam longint MINS = -(longint'(1) << (W - 1));

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic [2:0]   aluop;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] result_lo;
  logic [W-1:0] result_hi;
  logic         zero;
  logic         overflow;
  logic         div_by_zero;
  logic         illegal;

  int n_checks = 0;
  int n_errors = 0;

  typedef struct {
    logic [W-1:0] lo;
    logic [W-1:0] hi;
    logic         z;
    logic         ov;
    logic         dz;
    logic         il;
    int           lat;
  } exp_t;

  alu_seq #(.WIDTH(W)) dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .a           (a),
    .b           (b),
    .aluop       (aluop),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .result_lo   (result_lo),
    .result_hi   (result_hi),
    .zero        (zero),
    .overflow    (overflow),
    .div_by_zero (div_by_zero),
    .illegal     (illegal)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  // Reference: signed overflow from wide signed arithmetic, products and
  // quotients from native operators; lat = extra edges after the accept edge.
  function automatic exp_t ref_model(input logic [W-1:0] x, input logic [W-1:0] y,
                                     input logic [2:0] op);
    exp_t           e;
    longint         s;
    logic [2*W-1:0] p;
    e.lo = '0; e.hi = '0; e.ov = 1'b0; e.dz = 1'b0; e.il = 1'b0; e.lat = 0;
    case (op)
      3'b000: e.lo = x & y;
      3'b001: e.lo = x | y;
      3'b100: e.lo = ~(x | y);
      3'b111: e.lo = (x < y) ? W'(1) : W'(0);
      3'b010: begin
        s = longint'($signed(x)) + longint'($signed(y));
        e.lo = s[W-1:0];
        e.ov = (s > MAXS) || (s < MINS);
      end
      3'b110: begin
        s = longint'($signed(x)) - longint'($signed(y));
        e.lo = s[W-1:0];
        e.ov = (s > MAXS) || (s < MINS);
      end
      3'b011: begin
        p = {{W{1'b0}}, x} * {{W{1'b0}}, y};
        e.lo = p[W-1:0];
        e.hi = p[2*W-1:W];
        e.lat = W;
      end
      default: begin
`ifdef ALU_SEQ_DIV_EN
        if (y == 0) begin
          e.lo = '1;
          e.hi = x;
          e.dz = 1'b1;
        end else begin
          e.lo = x / y;
          e.hi = x % y;
          e.lat = W;
        end
`else
        e.il = 1'b1;
`endif
      end
    endcase
    e.z = (e.lo == 0);
    return e;
  endfunction

  task automatic check_outputs(input exp_t e, input string pfx);
    check({pfx, "_valid"}, out_valid, 1);
    check({pfx, "_lo"}, result_lo, e.lo);
    check({pfx, "_hi"}, result_hi, e.hi);
    check({pfx, "_zero"}, zero, e.z);
    check({pfx, "_ovf"}, overflow, e.ov);
    check({pfx, "_dbz"}, div_by_zero, e.dz);
    check({pfx, "_ill"}, illegal, e.il);
  endtask

  // One transaction: accept, wait for the result, hold backpressure, optionally release.
  task automatic run_op(input logic [W-1:0] x, input logic [W-1:0] y, input logic [2:0] op,
                        input int hold, input bit rel, input string pfx);
    exp_t e;
    int   lat;
    int   waitc;
    bit   busy_ready;
    e = ref_model(x, y, op);
    @(negedge clk);
    a = x; b = y; aluop = op; in_valid = 1'b1;
    waitc = 0;
    while (!in_ready && waitc < 50) begin
      @(negedge clk);
      waitc++;
    end
    check({pfx, "_accept_wait"}, (waitc < 50), 1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    a = $urandom; b = $urandom; aluop = 3'($urandom_range(0, 7));
    lat = 0;
    busy_ready = 1'b0;
    while (!out_valid && lat < 200) begin
      if (in_ready) busy_ready = 1'b1;
      @(posedge clk); #1;
      lat++;
    end
    check({pfx, "_latency"}, lat, e.lat);
    if (e.lat > 0) check({pfx, "_busy_in_ready"}, busy_ready, 0);
    check_outputs(e, pfx);
    repeat (hold) begin
      @(posedge clk); #1;
    end
    if (hold > 0) begin
      check_outputs(e, {pfx, "_held"});
      check({pfx, "_held_in_ready"}, in_ready, 0);
    end
    if (rel) begin
      @(negedge clk);
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
      check({pfx, "_released"}, out_valid, 0);
    end
  endtask

  initial begin
    exp_t        e;
    int          stale;
    logic [2:0]  sc_ops [6];
    logic [W-1:0] x, y;
    logic [2:0]  op;
    sc_ops = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b110, 3'b111};

    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0; aluop = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_in_ready", in_ready, 0);
    check("rst_valid", out_valid, 0);
    check("rst_lo", result_lo, 0);
    check("rst_hi", result_hi, 0);
    check("rst_flags", {zero, overflow, div_by_zero, illegal}, 0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("post_rst_in_ready", in_ready, 1);

    // Directed cases
    run_op(32'h7FFF_FFFF, 32'd1, ALUOP_ADD, 0, 1'b1, "add_ovf");
    run_op(32'd5, 32'd5, ALUOP_SUB, 0, 1'b1, "sub_zero");
    run_op(32'h8000_0000, 32'd1, ALUOP_SUB, 0, 1'b1, "sub_ovf");
    run_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, ALUOP_MULU, 0, 1'b1, "mul_max");
    run_op(32'd100, 32'd7, ALUOP_DIVU, 0, 1'b1, "div_100_7");
    run_op(32'd9, 32'd0, ALUOP_DIVU, 0, 1'b1, "div_by_0");
    run_op(32'd8, 32'd2, ALUOP_DIVU, 0, 1'b1, "div_8_2");
    run_op(32'd3, 32'd9, ALUOP_SLTU, 0, 1'b1, "sltu");

    // Backpressure on OR, then release with a simultaneous AND accept
    run_op(32'hF0F0_0000, 32'h0000_0F0F, ALUOP_OR, 5, 1'b0, "bp_or");
    @(negedge clk);
    out_ready = 1'b1; in_valid = 1'b1;
    a = 32'hFF00_FF00; b = 32'h0FF0_0FF0; aluop = ALUOP_AND;
    e = ref_model(a, b, ALUOP_AND);
    #1;
    check("bp_release_in_ready", in_ready, 1);
    @(posedge clk); #1;
    in_valid = 1'b0; out_ready = 1'b0;
    check_outputs(e, "bp_and");
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;

    // Back-to-back single-cycle ops with out_ready held high
    @(negedge clk);
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      x = $urandom; y = $urandom;
      op = sc_ops[$urandom_range(0, 5)];
      a = x; b = y; aluop = op; in_valid = 1'b1;
      e = ref_model(x, y, op);
      #1;
      check("b2b_in_ready", in_ready, 1);
      @(posedge clk); #1;
      check_outputs(e, "b2b");
      @(negedge clk);
    end
    in_valid = 1'b0;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check("b2b_drain", out_valid, 0);

    // Reset in the middle of a multiply
    @(negedge clk);
    a = 32'h1234_5678; b = 32'h9ABC_DEF0; aluop = ALUOP_MULU; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (9) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("midrst_in_ready", in_ready, 0);
    @(posedge clk); #1;
    check("midrst_valid", out_valid, 0);
    check("midrst_lo", result_lo, 0);
    check("midrst_hi", result_hi, 0);
    check("midrst_flags", {zero, overflow, div_by_zero, illegal}, 0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("midrst_idle", in_ready, 1);
    stale = 0;
    repeat (W + 8) begin
      @(posedge clk); #1;
      if (out_valid) stale++;
    end
    check("midrst_no_stale", stale, 0);

    // Randomized mix of all op codes
    for (int i = 0; i < 30; i++) begin
      x = $urandom;
      case ($urandom_range(0, 3))
        0:       y = '0;
        1:       y = W'($urandom_range(1, 15));
        default: y = $urandom;
      endcase
      op = 3'($urandom_range(0, 7));
      run_op(x, y, op, $urandom_range(0, 3), 1'b1, "rand");
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/alu_seq.md
# alu_seq

Parametrised, handshaked successor to the single-cycle pipeline ALU. It executes the existing logic and arithmetic ops in one cycle and adds unsigned iterative multiply and divide. The result is held in an output register until the consumer takes it. It sits in EX and stalls the pipeline via `in_ready` while a multi-cycle op is in flight.

## Interface
- `WIDTH`, 32: operand width; legal range ≥ 2.
- `clk` input 1: single clock, rising edge.
- `rst` input 1: synchronous, active-high reset.
- `in_valid` input 1: operand/op presented.
- `in_ready` output 1: block accepts when `in_valid && in_ready` at a clk edge.
- `a` input WIDTH: operand A.
- `b` input WIDTH: operand B.
- `aluop` input 3: op code; encoding unchanged from the pipeline ALU, plus the two new codes listed under Operation.
- `out_valid` output 1: result registers valid.
- `out_ready` input 1: consumer takes result when `out_valid && out_ready`.
- `result_lo` output WIDTH: primary result / product low half / quotient.
- `result_hi` output WIDTH: product high half / remainder; 0 for single-cycle ops.
- `zero` output 1: `result_lo == 0`.
- `overflow` output 1: signed two's-complement overflow of ADD/SUB; 0 otherwise.
- `div_by_zero` output 1: DIVU with `b == 0`.
- `illegal` output 1: unused op code, or DIVU when the divider is compiled out.

## Operation
- Op codes:
  - 000 AND, 001 OR, 010 ADD, 110 SUB, 100 NOR, 111 SLTU (`a < b` unsigned → 1 else 0).
  - 011 MULU: 2·WIDTH product; high half → `result_hi`.
  - 101 DIVU: quotient → `result_lo`, remainder → `result_hi`.
- ADD/SUB wrap modulo 2^WIDTH.
  - ADD overflow = (a[W-1] == b[W-1]) && (sum[W-1] != a[W-1]).
  - SUB overflow = (a[W-1] != b[W-1]) && (diff[W-1] != a[W-1]).
- Unused codes: none remain within the 3-bit field in the full build. An op that is `illegal` completes in 1 cycle with all results 0 and `illegal` = 1.
- FSM states:
  - IDLE → DONE on accepting a single-cycle op.
  - IDLE → MUL or DIV on accepting MULU/DIVU.
  - MUL/DIV → DONE after WIDTH iterations; a WIDTH-wide counter counts down from WIDTH-1.
  - DONE → IDLE on `out_ready` with no new accept.
  - DONE → DONE/MUL/DIV on `out_ready` with a simultaneous accept.
- MULU: shift-add, one multiplier bit per cycle, into a 2·WIDTH accumulator.
- DIVU: restoring, one quotient bit per cycle.
  - `b == 0`: skip iteration and go to DONE next cycle.
  - Results: quotient = all ones, remainder = `a`, `div_by_zero` = 1.
- `in_ready` = (state == IDLE) || (state == DONE && out_ready); forced 0 while `rst` = 1.
- Operands are latched at accept; `a`/`b`/`aluop` are don't-care afterwards.

## Timing
- Accept edge = cycle 0.
- Single-cycle ops and DIVU-by-zero: `out_valid` = 1 from cycle 1.
- MULU/DIVU: MUL/DIV state occupies cycles 1..WIDTH; `out_valid` = 1 from cycle WIDTH+1 (33 for WIDTH = 32).
- Output registers and flags are stable while `out_valid && !out_ready`; they change only on a new completion.
- Back-to-back single-cycle ops with `out_ready` held at 1: one result per cycle.
- Reset values:
  - state IDLE.
  - `out_valid`, `result_lo`, `result_hi`, `zero`, `overflow`, `div_by_zero`, `illegal` all 0.
  - Counter 0.
  - `in_ready` = 0 during reset, 1 the first cycle after.
- Reset mid-MUL/DIV or in DONE aborts the op; no result is emitted.

## Configuration
- `ALU_SEQ_DIV_EN` defined: DIVU datapath and DIV state are compiled in.
- `ALU_SEQ_DIV_EN` undefined: no divider logic. DIVU completes in 1 cycle with results 0, `illegal` = 1 and `div_by_zero` = 0. MULU is unaffected.

## Structure
- Package `alu_pkg` holds:
  - op-code localparams (`ALUOP_AND` … `ALUOP_DIVU`);
  - the FSM state enum (IDLE, MUL, DIV, DONE).
- One sub-module, `alu_iter_unit`: shift-add multiplier plus restoring divider step logic, counter and accumulator, with start/done pulses.
- The top holds the handshake FSM, the single-cycle ops and the output registers.

## Test plan
- ADD `a`=0x7FFFFFFF, `b`=1 → cycle 1: `result_lo`=0x80000000, `overflow`=1, `zero`=0. SUB 5−5 → `result_lo`=0, `zero`=1, `overflow`=0.
- MULU 0xFFFFFFFF × 0xFFFFFFFF → `out_valid` at cycle 33: `result_hi`=0xFFFFFFFE, `result_lo`=0x00000001; `in_ready`=0 during cycles 1..32.
- DIVU 100 / 7 → cycle 33: `result_lo`=14, `result_hi`=2. DIVU 9 / 0 → cycle 1: `result_lo`=0xFFFFFFFF, `result_hi`=9, `div_by_zero`=1.
- Backpressure: `out_ready`=0 for 5 cycles after an OR result → outputs stable, `in_ready`=0. Then `out_ready`=1 with a simultaneous new AND accepted → the next result appears on the following cycle.
- Assert `rst` at cycle 10 of a MULU → next cycle: `out_valid`=0, state IDLE, all outputs 0; no stale result ever appears.
- Build without `ALU_SEQ_DIV_EN`: DIVU 8 / 2 → cycle 1: `illegal`=1, `result_lo`=0, `result_hi`=0.
